// File: rtl/reservation_station.sv
// Out-of-order issue buffer for non-load/store instructions: holds renamed
// instructions, snoops the ALU and load CDBs, and issues one ready entry per cycle.
module reservation_station #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_IDX_W = 4,
  parameter int OPT_W     = 6,
  parameter int WORD_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rs_rb,
  output logic                 rs_full,
  input  logic                 rs_ena,
  input  logic [OPT_W-1:0]     rs_opt,
  input  logic [ROB_IDX_W-1:0] rs_src1,
  input  logic [ROB_IDX_W-1:0] rs_src2,
  input  logic [WORD_W-1:0]    rs_val1,
  input  logic [WORD_W-1:0]    rs_val2,
  input  logic [WORD_W-1:0]    rs_imm,
  input  logic [ROB_IDX_W-1:0] rs_rob_idx,
  input  logic                 cdb_alu_valid,
  input  logic [ROB_IDX_W-1:0] cdb_alu_src,
  input  logic [WORD_W-1:0]    cdb_alu_val,
  input  logic                 cdb_ld_valid,
  input  logic [ROB_IDX_W-1:0] cdb_ld_src,
  input  logic [WORD_W-1:0]    cdb_ld_val,
  output logic                 alu_ena,
  output logic [OPT_W-1:0]     alu_opt,
  output logic [WORD_W-1:0]    alu_val1,
  output logic [WORD_W-1:0]    alu_val2,
  output logic [WORD_W-1:0]    alu_imm,
  output logic [ROB_IDX_W-1:0] alu_rob_idx
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam int OPW   = ROB_IDX_W + WORD_W;

  logic [RS_SIZE-1:0]   valid_r;
  logic [OPT_W-1:0]     opt_r     [RS_SIZE];
  logic [ROB_IDX_W-1:0] src1_r    [RS_SIZE];
  logic [ROB_IDX_W-1:0] src2_r    [RS_SIZE];
  logic [WORD_W-1:0]    val1_r    [RS_SIZE];
  logic [WORD_W-1:0]    val2_r    [RS_SIZE];
  logic [WORD_W-1:0]    imm_r     [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_idx_r [RS_SIZE];

  logic                 alu_ena_r;
  logic [OPT_W-1:0]     alu_opt_r;
  logic [WORD_W-1:0]    alu_val1_r;
  logic [WORD_W-1:0]    alu_val2_r;
  logic [WORD_W-1:0]    alu_imm_r;
  logic [ROB_IDX_W-1:0] alu_rob_idx_r;

  logic [RS_SIZE-1:0]   ready_s;
  logic                 issue_found_s;
  logic [IDX_W-1:0]     issue_idx_s;
  logic                 free_found_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic [CNT_W-1:0]     valid_cnt_s;
  logic [OPW-1:0]       ins_op1_s;
  logic [OPW-1:0]       ins_op2_s;

  // Resolve one operand against both CDBs; ALU broadcast wins, tag 0 never matches.
  function automatic logic [OPW-1:0] snoop(input logic [ROB_IDX_W-1:0] src,
                                            input logic [WORD_W-1:0]    val);
    if ((src != {ROB_IDX_W{1'b0}}) && cdb_alu_valid && (cdb_alu_src == src)) begin
      return {{ROB_IDX_W{1'b0}}, cdb_alu_val};
    end else if ((src != {ROB_IDX_W{1'b0}}) && cdb_ld_valid && (cdb_ld_src == src)) begin
      return {{ROB_IDX_W{1'b0}}, cdb_ld_val};
    end else begin
      return {src, val};
    end
  endfunction

  // Lowest-index ready/free selection, occupancy count and insert-time capture.
  always_comb begin
    ready_s       = '0;
    issue_found_s = 1'b0;
    issue_idx_s   = '0;
    free_found_s  = 1'b0;
    free_idx_s    = '0;
    valid_cnt_s   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready_s[i]    = valid_r[i] && (src1_r[i] == {ROB_IDX_W{1'b0}}) &&
                      (src2_r[i] == {ROB_IDX_W{1'b0}});
      issue_idx_s   = ready_s[i] ? IDX_W'(i) : issue_idx_s;
      issue_found_s = issue_found_s | ready_s[i];
      free_idx_s    = !valid_r[i] ? IDX_W'(i) : free_idx_s;
      free_found_s  = free_found_s | !valid_r[i];
      valid_cnt_s   = valid_cnt_s + CNT_W'(valid_r[i]);
    end
    ins_op1_s = snoop(rs_src1, rs_val1);
    ins_op2_s = snoop(rs_src2, rs_val2);
  end

  assign rs_full = (valid_cnt_s + CNT_W'(rs_ena)) >= CNT_W'(RS_SIZE);

  // Entry state and issue register; snoop, issue and insert touch distinct entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r       <= '0;
      alu_ena_r     <= 1'b0;
      alu_opt_r     <= '0;
      alu_val1_r    <= '0;
      alu_val2_r    <= '0;
      alu_imm_r     <= '0;
      alu_rob_idx_r <= '0;
    end else if (rs_rb) begin
      valid_r   <= '0;
      alu_ena_r <= 1'b0;
    end else begin
      alu_ena_r <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid_r[i]) begin
          {src1_r[i], val1_r[i]} <= snoop(src1_r[i], val1_r[i]);
          {src2_r[i], val2_r[i]} <= snoop(src2_r[i], val2_r[i]);
        end
      end
      if (rdy && issue_found_s) begin
        valid_r[issue_idx_s] <= 1'b0;
        alu_ena_r            <= 1'b1;
        alu_opt_r            <= opt_r[issue_idx_s];
        alu_val1_r           <= val1_r[issue_idx_s];
        alu_val2_r           <= val2_r[issue_idx_s];
        alu_imm_r            <= imm_r[issue_idx_s];
        alu_rob_idx_r        <= rob_idx_r[issue_idx_s];
      end
      if (rs_ena && free_found_s) begin
        valid_r[free_idx_s]                        <= 1'b1;
        opt_r[free_idx_s]                          <= rs_opt;
        imm_r[free_idx_s]                          <= rs_imm;
        rob_idx_r[free_idx_s]                      <= rs_rob_idx;
        {src1_r[free_idx_s], val1_r[free_idx_s]}   <= ins_op1_s;
        {src2_r[free_idx_s], val2_r[free_idx_s]}   <= ins_op2_s;
      end
    end
  end

  assign alu_ena     = alu_ena_r;
  assign alu_opt     = alu_opt_r;
  assign alu_val1    = alu_val1_r;
  assign alu_val2    = alu_val2_r;
  assign alu_imm     = alu_imm_r;
  assign alu_rob_idx = alu_rob_idx_r;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: stimulus pushes expected issues into a
// queue, a negedge monitor pops and compares every alu_ena pulse.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst, rdy, rs_rb, rs_full, rs_ena;
  logic [5:0]  rs_opt;
  logic [3:0]  rs_src1, rs_src2, rs_rob_idx;
  logic [31:0] rs_val1, rs_val2, rs_imm;
  logic        cdb_alu_valid, cdb_ld_valid;
  logic [3:0]  cdb_alu_src, cdb_ld_src;
  logic [31:0] cdb_alu_val, cdb_ld_val;
  logic        alu_ena;
  logic [5:0]  alu_opt;
  logic [31:0] alu_val1, alu_val2, alu_imm;
  logic [3:0]  alu_rob_idx;

  typedef struct packed {
    logic [5:0]  opt;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] imm;
    logic [3:0]  rob;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_rb(rs_rb), .rs_full(rs_full),
    .rs_ena(rs_ena), .rs_opt(rs_opt), .rs_src1(rs_src1), .rs_src2(rs_src2),
    .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
    .cdb_ld_valid(cdb_ld_valid), .cdb_ld_src(cdb_ld_src), .cdb_ld_val(cdb_ld_val),
    .alu_ena(alu_ena), .alu_opt(alu_opt), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_rob_idx(alu_rob_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every issue pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && alu_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("alu_opt", 32'(alu_opt), 32'(e.opt));
        chk("alu_val1", alu_val1, e.val1);
        chk("alu_val2", alu_val2, e.val2);
        chk("alu_imm", alu_imm, e.imm);
        chk("alu_rob_idx", 32'(alu_rob_idx), 32'(e.rob));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rs_rb = 1'b0; rs_ena = 1'b0; rs_opt = 6'd0; rs_src1 = 4'd0; rs_src2 = 4'd0;
    rs_val1 = 32'd0; rs_val2 = 32'd0; rs_imm = 32'd0; rs_rob_idx = 4'd0;
    cdb_alu_valid = 1'b0; cdb_alu_src = 4'd0; cdb_alu_val = 32'd0;
    cdb_ld_valid = 1'b0; cdb_ld_src = 4'd0; cdb_ld_val = 32'd0;
  endtask

  task automatic ins(input logic [5:0] opt, input logic [3:0] s1, input logic [31:0] v1,
                     input logic [3:0] s2, input logic [31:0] v2, input logic [31:0] imm,
                     input logic [3:0] rob);
    rs_ena = 1'b1; rs_opt = opt; rs_src1 = s1; rs_val1 = v1; rs_src2 = s2;
    rs_val2 = v2; rs_imm = imm; rs_rob_idx = rob;
  endtask

  task automatic push(input logic [5:0] opt, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] imm, input logic [3:0] rob);
    exp_t e;
    e.opt = opt; e.val1 = v1; e.val2 = v2; e.imm = imm; e.rob = rob;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_alu_ena", 32'(alu_ena), 32'd0);
    chk("reset_alu_val1", alu_val1, 32'd0);
    chk("reset_alu_opt", 32'(alu_opt), 32'd0);
    chk("reset_rs_full", 32'(rs_full), 32'd0);

    // Ready-at-insert entry issues one cycle after the insert edge.
    ins(6'd3, 4'd0, 32'd5, 4'd0, 32'd7, 32'h11, 4'd2);
    push(6'd3, 32'd5, 32'd7, 32'h11, 4'd2);
    tick(); idle();
    chk("t1_no_issue_at_insert", 32'(alu_ena), 32'd0);
    tick();
    chk("t1_issue", 32'(alu_ena), 32'd1);
    tick();
    chk("t1_pulse_and_empty", 32'(alu_ena), 32'd0);

    // Load CDB wakes a pending operand.
    ins(6'd4, 4'd4, 32'd0, 4'd0, 32'd3, 32'h22, 4'd5);
    push(6'd4, 32'hDEAD, 32'd3, 32'h22, 4'd5);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait", 32'(alu_ena), 32'd0);
      tick();
    end
    cdb_ld_valid = 1'b1; cdb_ld_src = 4'd4; cdb_ld_val = 32'hDEAD;
    tick(); idle();
    chk("t2_not_yet", 32'(alu_ena), 32'd0);
    tick();
    chk("t2_issue", 32'(alu_ena), 32'd1);

    // Capture on insert with both CDBs matching: ALU wins.
    ins(6'd5, 4'd0, 32'd1, 4'd6, 32'd0, 32'h33, 4'd7);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd6; cdb_alu_val = 32'd9;
    cdb_ld_valid = 1'b1; cdb_ld_src = 4'd6; cdb_ld_val = 32'd1;
    push(6'd5, 32'd1, 32'd9, 32'h33, 4'd7);
    tick(); idle();
    chk("t3_not_yet", 32'(alu_ena), 32'd0);
    tick();
    chk("t3_issue", 32'(alu_ena), 32'd1);
    tick();

    // Fill all 8 entries with a dependent instruction.
    for (int i = 0; i < 8; i++) begin
      ins(6'(i + 10), 4'd1, 32'd0, 4'd0, 32'(i), 32'(i * 16), 4'(i + 8));
      #1;
      chk("t4_full_on_insert", 32'(rs_full), (i == 7) ? 32'd1 : 32'd0);
      tick();
      chk("t4_no_issue", 32'(alu_ena), 32'd0);
    end
    idle();
    #1;
    chk("t4_full_held", 32'(rs_full), 32'd1);
    tick();
    chk("t4_full_idle", 32'(rs_full), 32'd1);
    for (int i = 0; i < 8; i++) push(6'(i + 10), 32'h100, 32'(i), 32'(i * 16), 4'(i + 8));
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd1; cdb_alu_val = 32'h100;
    tick(); idle();
    chk("t4_bcast_no_issue", 32'(alu_ena), 32'd0);
    chk("t4_bcast_full", 32'(rs_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_issue_stream", 32'(alu_ena), 32'd1);
      chk("t4_full_dropped", 32'(rs_full), 32'd0);
    end
    tick();
    chk("t4_drained", 32'(alu_ena), 32'd0);

    // Rollback with simultaneous insert and broadcast.
    for (int i = 0; i < 3; i++) begin
      ins(6'(i + 20), 4'd3, 32'd0, 4'd0, 32'd0, 32'd0, 4'(i + 1));
      tick();
    end
    ins(6'd30, 4'd0, 32'd1, 4'd0, 32'd2, 32'd0, 4'd9);
    rs_rb = 1'b1;
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd3; cdb_alu_val = 32'd77;
    tick(); idle();
    #1;
    chk("t5_rb_full", 32'(rs_full), 32'd0);
    chk("t5_rb_no_issue", 32'(alu_ena), 32'd0);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd3; cdb_alu_val = 32'd77;
    tick(); idle();
    tick();
    chk("t5_flushed", 32'(alu_ena), 32'd0);
    ins(6'd31, 4'd0, 32'hA, 4'd0, 32'hB, 32'hC, 4'd1);
    push(6'd31, 32'hA, 32'hB, 32'hC, 4'd1);
    tick(); idle();
    tick();
    chk("t5_post_rb_issue", 32'(alu_ena), 32'd1);
    tick();

    // rdy stall: ready entry plus a second insert, then drain in index order.
    rdy = 1'b0;
    ins(6'd40, 4'd0, 32'd40, 4'd0, 32'd41, 32'd42, 4'd3);
    push(6'd40, 32'd40, 32'd41, 32'd42, 4'd3);
    tick();
    chk("t6_stall0", 32'(alu_ena), 32'd0);
    ins(6'd50, 4'd0, 32'd50, 4'd0, 32'd51, 32'd52, 4'd4);
    push(6'd50, 32'd50, 32'd51, 32'd52, 4'd4);
    tick(); idle();
    chk("t6_stall1", 32'(alu_ena), 32'd0);
    tick();
    chk("t6_stall2", 32'(alu_ena), 32'd0);
    tick();
    chk("t6_stall3", 32'(alu_ena), 32'd0);
    rdy = 1'b1;
    tick();
    chk("t6_issue_a", 32'(alu_ena), 32'd1);
    tick();
    chk("t6_issue_b", 32'(alu_ena), 32'd1);
    tick();
    chk("t6_done", 32'(alu_ena), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Out-of-order issue buffer for all non-load/store instructions.
- Sits directly downstream of the decode/dispatch stage: it accepts one renamed instruction per cycle on the rs_* bus and holds it until both operands are available.
- While waiting, it captures operands from the two CDB broadcasts (ALU and load).
- Each cycle it issues at most one ready instruction to the ALU.

Parameters:
- RS_SIZE, 8, number of entries; power of two.
- ROB_IDX_W, 4, ROB index width; index 0 means "no dependency / value present".
- OPT_W, 6, decoded opcode width.
- WORD_W, 32, data word width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low freezes issue
- rs_rb  in  1  rollback; flushes all entries
- rs_full  out  1  combinational; high when (valid entries + rs_ena) >= RS_SIZE
- rs_ena  in  1  insert strobe from dispatch
- rs_opt  in  OPT_W  opcode
- rs_src1  in  ROB_IDX_W  producer tag of operand 1; 0 means rs_val1 is final
- rs_src2  in  ROB_IDX_W  producer tag of operand 2; 0 means rs_val2 is final
- rs_val1  in  WORD_W  operand 1 value
- rs_val2  in  WORD_W  operand 2 value
- rs_imm  in  WORD_W  immediate
- rs_rob_idx  in  ROB_IDX_W  destination ROB entry
- cdb_alu_valid  in  1  ALU broadcast valid
- cdb_alu_src  in  ROB_IDX_W  ALU broadcast tag
- cdb_alu_val  in  WORD_W  ALU broadcast value
- cdb_ld_valid  in  1  load broadcast valid
- cdb_ld_src  in  ROB_IDX_W  load broadcast tag
- cdb_ld_val  in  WORD_W  load broadcast value
- alu_ena  out  1  registered one-cycle issue strobe
- alu_opt  out  OPT_W  issued opcode
- alu_val1  out  WORD_W  issued operand 1
- alu_val2  out  WORD_W  issued operand 2
- alu_imm  out  WORD_W  issued immediate
- alu_rob_idx  out  ROB_IDX_W  issued destination ROB entry

Behaviour:
- Entry state: valid, opt, src1, src2, val1, val2, imm, rob_idx. An entry is ready when valid and src1==0 and src2==0 (both registered values).
- Reset (rst high at a clk edge):
  - All valid bits cleared.
  - alu_ena=0 and all alu_* data outputs=0.
  - rst has priority over everything else.
- Priority after reset: rs_rb > normal operation.
- Rollback (rs_rb high, rst low):
  - All valid bits cleared and alu_ena<=0.
  - rs_ena in the same cycle is ignored.
  - CDB in the same cycle is ignored.
- alu_ena defaults to 0 at every edge (pulse semantics). alu_* data outputs hold their last issued values.
- Issue (rdy high, no rst/rs_rb):
  - Select the lowest-index ready entry.
  - At the edge: alu_ena<=1, alu_* <= entry fields, and the entry's valid is cleared.
  - Latency is one cycle: an entry whose src fields became 0 at edge N can produce alu_ena high after edge N+1.
  - An instruction inserted at edge N is first eligible for issue at edge N+1, even if both of its srcs are 0.
- Insert (rs_ena high, no rst/rs_rb; performed regardless of rdy):
  - Write into the lowest-index invalid entry.
  - The entry freed by an issue in the same cycle is not reused that cycle.
  - The dispatcher honours rs_full, so an insert never finds the RS full. If it does, the insert is dropped; the bench asserts this never happens.
- CDB capture on insert: compare each incoming nonzero rs_srcN against the valid CDB tags.
  - On a match, store the src as 0 and store the CDB value.
  - If both CDBs match, the ALU CDB wins.
- CDB snoop (regardless of rdy, no rst/rs_rb): for every valid entry and each operand with a nonzero src:
  - If cdb_alu_valid and the src matches, set src<=0 and val<=cdb_alu_val.
  - Otherwise, if cdb_ld_valid and the src matches, take cdb_ld_val.
  - Both operands of one entry may be resolved in the same cycle.
  - A CDB tag of 0 never matches.
- rdy low:
  - No issue occurs and alu_ena<=0.
  - Insert and CDB snoop still occur, so no dispatcher pulse is lost.
- Simultaneous insert + issue + snoop in one cycle is legal. Each operates on a distinct entry, except that snoop also updates the entry being inserted, per the capture-on-insert rule.
- rs_full counts the current valid entries plus the incoming rs_ena. An issue in the same cycle does not lower rs_full (conservative).

Test Plan:
- Reset then insert {opt=3, src1=0, val1=5, src2=0, val2=7, rob_idx=2} → alu_ena high exactly one cycle after the insert edge, with alu_val1=5, alu_val2=7, alu_rob_idx=2; the RS is then empty.
- Insert with src1=4 (not ready); three cycles later pulse cdb_ld_valid, src=4, val=0xDEAD → alu_ena one cycle after the broadcast edge, alu_val1=0xDEAD.
- Insert with src2=6 while cdb_alu_valid, src=6, val=9 and cdb_ld_valid, src=6, val=1 in the same cycle → issued with alu_val2=9 on the next cycle.
- Insert 8 dependent entries (src1=1) → rs_full is high while the 8th insert is presented and remains high; broadcast tag 1 → issues happen one per cycle over 8 consecutive cycles, in entry-index order; rs_full drops after the first issue.
- With 3 entries pending, assert rs_rb together with rs_ena → no alu_ena afterwards, rs_full=0, and a subsequent ready insert issues normally.
- Hold rdy low for 4 cycles with a ready entry present and one insert arriving → no alu_ena during the stall; after rdy rises, both entries issue on consecutive cycles, lowest index first.
